// File: rtl/z80_io_bridge_pkg.sv
// Shared types for the Z80 CPU I/O to VDP port bridge.
// Holds the access state encoding and the address pad width.
package vdp_io_pkg;

    localparam int ADR_PAD_W = 14;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DATA,
        HOLD
    } io_state_e;

endpackage

// File: rtl/z80_io_bridge_if.sv
// CPU-side and VDP-side signals of the Z80 I/O bridge.
// master drives the CPU strobes and VDP read data, slave is the bridge.
interface z80_io_bridge_if;

    logic        csr_n;
    logic        csw_n;
    logic [1:0]  mode;
    logic [7:0]  cd_in;
    logic [7:0]  vdp_dbi;
    logic        req;
    logic        wrt;
    logic [15:0] adr;
    logic [7:0]  dbo;
    logic [7:0]  cpu_dbi;
    logic        busy;

    modport master (
        output csr_n, csw_n, mode, cd_in, vdp_dbi,
        input  req, wrt, adr, dbo, cpu_dbi, busy
    );

    modport slave (
        input  csr_n, csw_n, mode, cd_in, vdp_dbi,
        output req, wrt, adr, dbo, cpu_dbi, busy
    );

endinterface

// File: rtl/z80_io_bridge_io_strobe_filter.sv
// Two-flop synchroniser plus optional run-length glitch filter for one strobe.
// Filter stage present only when CPU_IO_GLITCH_FILTER_EN is defined.
module io_strobe_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe_n,
    output logic filt_n
);

    logic sync1_q;
    logic sync2_q;

    // Empty marker block; elaboration tolerates only 1..8.
    if (FILTER_LEN < 1 || FILTER_LEN > 8) begin : g_filter_len_range
    end

    // Bring the asynchronous strobe into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= strobe_n;
            sync2_q <= sync1_q;
        end
    end

`ifdef CPU_IO_GLITCH_FILTER_EN
    localparam logic [2:0] LAST = 3'(FILTER_LEN - 1);

    logic       filt_q;
    logic [2:0] cnt_q;

    // Accept a new level only after FILTER_LEN differing samples in a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= 1'b1;
            cnt_q  <= 3'd0;
        end else if (sync2_q == filt_q) begin
            cnt_q  <= 3'd0;
        end else if (cnt_q == LAST) begin
            filt_q <= sync2_q;
            cnt_q  <= 3'd0;
        end else begin
            cnt_q  <= cnt_q + 3'd1;
        end
    end

    assign filt_n = filt_q;
`else
    assign filt_n = sync2_q;
`endif

endmodule

// File: rtl/z80_io_bridge.sv
// Z80 I/O strobe to VDP single-cycle request bridge.
// Strobe glitch filter enabled by defining CPU_IO_GLITCH_FILTER_EN.
module z80_io_bridge
    import vdp_io_pkg::*;
#(
    parameter int FILTER_LEN = 3,
    parameter int READ_LAT   = 2
) (
    input  logic            clk,
    input  logic            reset,
    z80_io_bridge_if.slave  bus
);

    io_state_e   state_q;
    io_state_e   state_d;
    logic        fcsr_n;
    logic        fcsw_n;
    logic        start;
    logic        lat_done;
    logic        wr_q;
    logic [3:0]  lat_q;
    logic [15:0] adr_q;
    logic [7:0]  dbo_q;
    logic [7:0]  cpu_q;

    io_strobe_filter #(.FILTER_LEN(FILTER_LEN)) u_rd_filt (
        .clk      (clk),
        .reset    (reset),
        .strobe_n (bus.csr_n),
        .filt_n   (fcsr_n)
    );

    io_strobe_filter #(.FILTER_LEN(FILTER_LEN)) u_wr_filt (
        .clk      (clk),
        .reset    (reset),
        .strobe_n (bus.csw_n),
        .filt_n   (fcsw_n)
    );

    // Both strobes low together is not a valid access.
    assign start    = fcsr_n ^ fcsw_n;
    assign lat_done = (lat_q == 4'(READ_LAT - 1));

    // Access state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next access state; HOLD waits for both strobes released.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (start) state_d = ISSUE;
            ISSUE:     state_d = wr_q ? HOLD : WAIT_DATA;
            WAIT_DATA: if (lat_done) state_d = HOLD;
            HOLD:      if (fcsr_n && fcsw_n) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Latch the access at issue, count read latency, capture read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            adr_q <= '0;
            dbo_q <= '0;
            wr_q  <= 1'b0;
            lat_q <= '0;
            cpu_q <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                adr_q <= {ADR_PAD_W'(0), bus.mode};
                dbo_q <= bus.cd_in;
                wr_q  <= ~fcsw_n;
            end
            if (state_q == WAIT_DATA) begin
                lat_q <= lat_q + 4'd1;
            end else begin
                lat_q <= '0;
            end
            if (state_q == WAIT_DATA && lat_done) begin
                cpu_q <= bus.vdp_dbi;
            end
        end
    end

    assign bus.req     = (state_q == ISSUE);
    assign bus.wrt     = (state_q == ISSUE) && wr_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.adr     = adr_q;
    assign bus.dbo     = dbo_q;
    assign bus.cpu_dbi = cpu_q;

endmodule

// File: tb/tb_z80_io_bridge.sv
// Self-checking bench for z80_io_bridge: cycle model plus directed checks.
// Builds with or without CPU_IO_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module tb_z80_io_bridge;

    localparam int FILTER_LEN = 3;
    localparam int READ_LAT   = 2;
`ifdef CPU_IO_GLITCH_FILTER_EN
    localparam int FL = FILTER_LEN;
`else
    localparam int FL = 0;
`endif
    localparam int NC = 4096;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    z80_io_bridge_if bus ();

    z80_io_bridge #(
        .FILTER_LEN (FILTER_LEN),
        .READ_LAT   (READ_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          k = 0;
    int          rst_edge = 0;
    bit          raw_r [NC];
    bit          raw_w [NC];
    bit          fr_h  [NC];
    bit          fw_h  [NC];
    bit          m_active = 0;
    bit          m_wr = 0;
    bit          m_req = 0;
    int          m_start = 0;
    int          m_done = 0;
    logic [15:0] m_adr = '0;
    logic [7:0]  m_dbo = '0;
    logic [7:0]  m_cpu = '0;

    function automatic bit raw_at(input bit is_w, input int j);
        return is_w ? raw_w[j] : raw_r[j];
    endfunction

    // Filtered level after edge kk from raw strobe history.
    function automatic bit filt(input bit is_w, input bit prev, input int kk);
        bit s;
        bit flip;
        if (FL == 0)
            return (kk - 1 > rst_edge) ? raw_at(is_w, kk - 1) : 1'b1;
        flip = 1'b1;
        for (int j = kk - FL + 1; j <= kk; j++) begin
            if (j <= rst_edge) begin
                flip = 1'b0;
            end else begin
                s = (j - 2 > rst_edge) ? raw_at(is_w, j - 2) : 1'b1;
                if (s == prev) flip = 1'b0;
            end
        end
        return flip ? ~prev : prev;
    endfunction

    initial forever begin
        bit pr;
        bit pw;
        @(posedge clk);
        k = k + 1;
        raw_r[k] = bus.csr_n;
        raw_w[k] = bus.csw_n;
        if (reset) begin
            rst_edge = k;
            m_active = 0;
            m_wr     = 0;
            m_req    = 0;
            m_adr    = '0;
            m_dbo    = '0;
            m_cpu    = '0;
            fr_h[k]  = 1'b1;
            fw_h[k]  = 1'b1;
        end else begin
            pr = fr_h[k - 1];
            pw = fw_h[k - 1];
            if (!m_active) begin
                if (pr ^ pw) begin
                    m_active = 1;
                    m_start  = k;
                    m_wr     = !pw;
                    m_adr    = {14'd0, bus.mode};
                    m_dbo    = bus.cd_in;
                    m_done   = m_wr ? k + 1 : k + 1 + READ_LAT;
                end
            end else begin
                if (!m_wr && k == m_done) m_cpu = bus.vdp_dbi;
                if (k > m_done && pr && pw) m_active = 0;
            end
            m_req   = m_active && (k == m_start);
            fr_h[k] = filt(1'b0, pr, k);
            fw_h[k] = filt(1'b1, pw, k);
        end
    end

    // ---------------- per-cycle compare + req monitor ----------------
    int          n_req = 0;
    int          req_k = 0;
    logic        req_wrt;
    logic [15:0] req_adr;
    logic [7:0]  q_dbo [$];
    bit          busy_seen = 0;

    initial forever begin
        @(negedge clk);
        if (k >= 1) begin
            chk("req", bus.req, m_req);
            chk("wrt", bus.wrt, m_req & m_wr);
            chk("busy", bus.busy, m_active);
            chk("adr", bus.adr, m_adr);
            chk("dbo", bus.dbo, m_dbo);
            chk("cpu_dbi", bus.cpu_dbi, m_cpu);
            if (bus.req) begin
                n_req++;
                req_k   = k;
                req_wrt = bus.wrt;
                req_adr = bus.adr;
                q_dbo.push_back(bus.dbo);
            end
            if (bus.busy) busy_seen = 1;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic strobe(input bit r, input bit w, input int lo, input int hi);
        bus.csr_n = ~r;
        bus.csw_n = ~w;
        repeat (lo) @(negedge clk);
        bus.csr_n = 1'b1;
        bus.csw_n = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    task automatic clr_mon();
        n_req = 0;
        busy_seen = 0;
        q_dbo.delete();
    endtask

    initial begin
        int k0;
        bit got;
        bus.csr_n   = 1'b1;
        bus.csw_n   = 1'b1;
        bus.mode    = 2'b00;
        bus.cd_in   = 8'h00;
        bus.vdp_dbi = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_req", bus.req, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_adr", bus.adr, 0);
        chk("rst_dbo", bus.dbo, 0);
        chk("rst_cpu", bus.cpu_dbi, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Single write.
        clr_mon();
        bus.mode  = 2'b01;
        bus.cd_in = 8'hA5;
        k0 = k;
        strobe(0, 1, 20, 20);
        chk("wr_nreq", n_req, 1);
        chk("wr_wrt", req_wrt, 1);
        chk("wr_adr", req_adr, 16'h0001);
        chk("wr_dbo", (q_dbo.size() > 0) ? q_dbo[0] : 8'hxx, 8'hA5);
        chk("wr_lat", req_k - k0, 3 + FL);
        chk("wr_idle", bus.busy, 0);

        // Single read, data held after release.
        clr_mon();
        bus.mode    = 2'b10;
        bus.vdp_dbi = 8'h3C;
        k0 = k;
        strobe(1, 0, 20, 20);
        chk("rd_nreq", n_req, 1);
        chk("rd_wrt", req_wrt, 0);
        chk("rd_adr", req_adr, 16'h0002);
        chk("rd_lat", req_k - k0, 3 + FL);
        chk("rd_cpu", bus.cpu_dbi, 8'h3C);
        bus.vdp_dbi = 8'h77;
        repeat (10) @(negedge clk);
        chk("rd_cpu_hold", bus.cpu_dbi, 8'h3C);

        // Both strobes together from IDLE.
        clr_mon();
        strobe(1, 1, 20, 20);
        chk("both_nreq", n_req, 0);
        chk("both_busy", busy_seen, 0);

        // Short and medium write pulses.
        clr_mon();
        strobe(0, 1, 1, 20);
        chk("glitch_nreq", n_req, (FL > 1) ? 0 : 1);
        clr_mon();
        strobe(0, 1, 5, 20);
        chk("pulse5_nreq", n_req, 1);

        // Read released while the access is in flight still completes.
        clr_mon();
        bus.mode    = 2'b11;
        bus.vdp_dbi = 8'h5E;
        strobe(1, 0, (FL > 0) ? FL : 1, 20);
        chk("short_rd_nreq", n_req, 1);
        chk("short_rd_cpu", bus.cpu_dbi, 8'h5E);
        chk("short_rd_idle", bus.busy, 0);

        // Strobe swap while in HOLD must not start a new access.
        clr_mon();
        bus.cd_in = 8'h5A;
        bus.csw_n = 1'b0;
        repeat (20) @(negedge clk);
        bus.csr_n = 1'b0;
        repeat (5) @(negedge clk);
        bus.csw_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("swap_busy", bus.busy, 1);
        bus.csr_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("swap_nreq", n_req, 1);
        chk("swap_idle", bus.busy, 0);

        // Reset during WAIT_DATA.
        clr_mon();
        bus.mode    = 2'b10;
        bus.vdp_dbi = 8'hFF;
        bus.csr_n   = 1'b0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.req) got = 1;
        end
        chk("rst_rd_req_seen", got, 1);
        @(negedge clk);
        chk("rst_rd_waiting", bus.busy, 1);
        reset     = 1'b1;
        bus.csr_n = 1'b1;
        @(negedge clk);
        chk("midrst_req", bus.req, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_cpu", bus.cpu_dbi, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_nreq", n_req, 1);
        chk("midrst_cpu_after", bus.cpu_dbi, 0);

        // Back-to-back writes.
        clr_mon();
        bus.mode  = 2'b00;
        bus.cd_in = 8'h11;
        strobe(0, 1, 20, 20);
        bus.cd_in = 8'h22;
        strobe(0, 1, 20, 20);
        chk("b2b_nreq", n_req, 2);
        chk("b2b_dbo0", (q_dbo.size() > 0) ? q_dbo[0] : 8'hxx, 8'h11);
        chk("b2b_dbo1", (q_dbo.size() > 1) ? q_dbo[1] : 8'hxx, 8'h22);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
